key_pulse_gen: RTL and testbench
================================

Name: key_pulse_gen

Overview:
- Input conditioner that produces the active-high, single-cycle key events consumed by the screen and game FSMs (e.g. the Enter event from KEY[3]).
- Takes raw active-low DE-series pushbuttons, synchronizes and debounces each one, and emits one press pulse per physical press plus a clean held level.
- Sits between top-level KEY pins and all game-play control FSMs.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
- NUM_KEYS, 4, number of independent pushbutton channels.
- DEBOUNCE_MS, 10, required stable time in ms before a level change is accepted.
- DBC_CYCLES, CLK_FREQ_HZ/1000*DEBOUNCE_MS (derived localparam, not overridable), debounce count in cycles.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- key_n  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk
- key_down  output  NUM_KEYS  debounced level per key, 1 = pressed
- key_press  output  NUM_KEYS  one-cycle pulse per accepted press
- key_release  output  NUM_KEYS  one-cycle pulse per accepted release

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, named reset_n. All state is cleared asynchronously on reset_n low and released synchronously.
- Reset values:
  - Synchronizer flops = 1 (unpressed).
  - key_down, key_press and key_release = 0.
  - Debounce counters = 0.
  - Every channel FSM = IDLE.
- Synchronizer: two flops per bit on key_n, followed by inversion. The resulting internal signal is s, with 1 = pressed. No logic reads key_n before the second flop.
- Per-channel FSM, states from the shared enum:
  - IDLE (key_down = 0): on s = 1, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: if s = 0, go back to IDLE; this is a bounce and produces no pulse. Otherwise increment the counter. When the counter reaches DBC_CYCLES-1 with s still 1, go to HELD and assert key_press for exactly that transition cycle.
  - HELD (key_down = 1): on s = 0, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT (key_down stays 1): if s = 1, go back to HELD with no pulse. When the counter reaches DBC_CYCLES-1 with s still 0, go to IDLE, pulse key_release and drop key_down.
- Outputs are registered: key_press, key_release and key_down all change on the same edge as the state transition.
- Latency: key_n is driven low and held from cycle 0. The synchronized value is visible at cycle 2. key_press is high in cycle 2+DBC_CYCLES, and key_down rises in that same cycle. Release latency is identical.
- Counter width is $clog2(DBC_CYCLES+1). The counter saturates and never wraps; it is only compared while in a WAIT state.
- A glitch shorter than DBC_CYCLES in either direction restarts qualification and produces no output.
- Exactly one key_press per accepted press, regardless of hold length, unless KEY_REPEAT_EN is defined.
- key_press and key_release are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses.
- Reset asserted mid-press: the channel returns to IDLE with no pulse. A key held through reset release is qualified as a new press, so key_press fires 2+DBC_CYCLES cycles after reset deasserts.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined:
  - Adds parameters REPEAT_DELAY_MS (default 500) and REPEAT_RATE_MS (default 100).
  - While in HELD, a second counter runs. After REPEAT_DELAY_MS of continuous hold, key_press re-pulses once, then once every REPEAT_RATE_MS until the key leaves HELD.
  - RELEASE_WAIT pauses the repeat counter. Returning to HELD from RELEASE_WAIT resumes it; it is not reset.
- When undefined: no repeat logic or counters are synthesized, and there is exactly one pulse per press.

Decomposition:
- Package game_pkg holds:
  - the typedef enum logic [1:0] key_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - the localparam function for ms-to-cycles conversion.
- One sub-module, key_debounce_ch: a single-channel synchronizer plus FSM. The top level instantiates it NUM_KEYS times with a generate loop.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000 and DEBOUNCE_MS=5, giving DBC_CYCLES=5.
- Clean press: key_n[3] goes 1→0 at cycle 10 and is held → key_press[3] high only in cycle 17, key_down[3] rises at cycle 17, other bits stay 0.
- Bounce: key_n[0] low for 3 cycles, high for 2, then low and held → no pulse during the bounce; key_press[0] comes 7 cycles after the final falling edge.
- Release: from held, key_n[3] goes 0→1 at cycle 100 → key_release[3] in cycle 107, key_down[3] falls at 107, no key_press.
- Long hold 1000 cycles with KEY_REPEAT_EN undefined → exactly one key_press. With KEY_REPEAT_EN defined, REPEAT_DELAY_MS=20 and REPEAT_RATE_MS=10 → re-pulses at 20 and 30 cycles after the first press, then every 10 cycles.
- Reset mid-qualification: reset_n pulsed low at cycle 14 during a press → all outputs 0 immediately; key still held gives key_press 7 cycles after reset_n rises.
- Simultaneous: key_n = 4'b0000 at cycle 10 → key_press = 4'b1111 in cycle 17.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game input conditioning logic.
//   key_state_t  : per-key debounce FSM states
//   ms_to_cycles : converts a time in ms to clock cycles for a given clock rate
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  // Divide before multiplying so large clock rates stay inside 32 bits.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single pushbutton channel: two-flop synchronizer followed by a debounce FSM.
// Optional macro KEY_REPEAT_EN adds auto-repeat of key_press while held.
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   key_n       : raw pushbutton, active-low, asynchronous to clk
//   key_down    : debounced level, 1 = pressed
//   key_press   : one-cycle pulse per accepted press (and per repeat)
//   key_release : one-cycle pulse per accepted release
module key_debounce_ch
  import game_pkg::*;
#(
  parameter int DBC_CYCLES = 500_000
`ifdef KEY_REPEAT_EN
  ,
  parameter int RPT_DELAY_CYCLES = 25_000_000,
  parameter int RPT_RATE_CYCLES  = 5_000_000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic key_down,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DBC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBC_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             s;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_hit;
  logic             key_down_q, key_down_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;

  // Synchronizer resets to the unpressed level so a reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Saturating increment; the WAIT states terminate before saturation anyway.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // Qualification completes when the incremented count reaches DBC_CYCLES-1,
  // which places the output change exactly DBC_CYCLES cycles after s settles.
  assign cnt_hit = (int'(cnt_q) + 1) >= (DBC_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY_CYCLES > RPT_RATE_CYCLES) ? RPT_DELAY_CYCLES
                                                                 : RPT_RATE_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_phase_q, rpt_phase_d;
  logic             rpt_hit;

  // First repeat waits the long delay, later repeats use the shorter rate.
  assign rpt_hit = (int'(rpt_q) + 1) >= (rpt_phase_q ? RPT_RATE_CYCLES : RPT_DELAY_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_down_q    <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  // Pulses default low every cycle; they are raised only on the transition
  // edge so press and release can never coincide.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_down_d    = key_down_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d         = rpt_q;
    rpt_phase_d   = rpt_phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s) begin
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            state_d     = HELD;
            key_down_d  = 1'b1;
            key_press_d = 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
`endif
          end
        end
      end
      HELD: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rpt_hit) begin
            key_press_d = 1'b1;
            rpt_d       = '0;
            rpt_phase_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        // The repeat counter is left untouched here so a bounce resumes it.
        if (s) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            state_d       = IDLE;
            key_down_d    = 1'b0;
            key_release_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_down    = key_down_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Conditions the raw active-low pushbuttons into clean levels and single-cycle
// press/release events for the game FSMs. One key_debounce_ch per key.
// Optional macro KEY_REPEAT_EN enables auto-repeat (REPEAT_DELAY_MS, REPEAT_RATE_MS).
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   key_n       : [NUM_KEYS] raw pushbuttons, active-low, asynchronous
//   key_down    : [NUM_KEYS] debounced level per key, 1 = pressed
//   key_press   : [NUM_KEYS] one-cycle pulse per accepted press
//   key_release : [NUM_KEYS] one-cycle pulse per accepted release
module key_pulse_gen
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_KEYS    = 4,
  parameter int DEBOUNCE_MS = 10
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int DBC_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
`ifdef KEY_REPEAT_EN
  localparam int RPT_DELAY_CYCLES = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
  localparam int RPT_RATE_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);
`endif

  // Channels share nothing, so simultaneous presses yield simultaneous pulses.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DBC_CYCLES       (DBC_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .RPT_DELAY_CYCLES (RPT_DELAY_CYCLES),
      .RPT_RATE_CYCLES  (RPT_RATE_CYCLES)
`endif
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_n       (key_n[g]),
      .key_down    (key_down[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g])
    );
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Randomised and directed bench for key_pulse_gen with a scoreboard.
// A behavioural model predicts every cycle's outputs and queues them; a
// separate monitor pops and compares against the DUT.
// Honours KEY_REPEAT_EN (repeat delay 20 ms, rate 10 ms at 1 kHz).
module tb_key_pulse_gen;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int NUM_KEYS    = 4;
  localparam int DEBOUNCE_MS = 5;
  localparam int DBC         = 5;
`ifdef KEY_REPEAT_EN
  localparam int RPT_DELAY   = 20;
  localparam int RPT_RATE    = 10;
`endif

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NUM_KEYS-1:0] key_n = '1;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  always #5 clk = ~clk;

  key_pulse_gen #(
    .CLK_FREQ_HZ     (CLK_FREQ_HZ),
    .NUM_KEYS        (NUM_KEYS),
    .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (10)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .key_down    (key_down),
    .key_press   (key_press),
    .key_release (key_release)
  );

  // Scoreboard and bookkeeping
  logic [11:0] expQ[$];
  int          checks = 0;
  int          passes = 0;
  int          cycleNum = 0;
  bit          countEn = 1'b0;
  int          modelPressCnt = 0;
  int          dutPressCnt = 0;

  // Model state: key_n history (edge t, t-1, t-2), accepted level, and run
  // lengths of the synchronised input disagreeing with the accepted level.
  logic [NUM_KEYS-1:0] h0 = '1, h1 = '1, h2 = '1;
  logic [NUM_KEYS-1:0] mDown = '0;
  int                  runLen[NUM_KEYS];
  int                  heldCnt[NUM_KEYS];
  bit                  rptPhase[NUM_KEYS];

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expVal);
    checks++;
    if (got !== expVal)
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleNum, got, expVal);
    else
      passes++;
  endtask

  // A level is accepted once the synchronised key has disagreed with it for
  // DBC consecutive cycles; any agreeing cycle restarts the count.
  task automatic modelStep();
    logic [NUM_KEYS-1:0] press, rel;
    press = '0;
    rel   = '0;
    if (!reset_n) begin
      h0 = '1; h1 = '1; h2 = '1;
      mDown = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        runLen[i] = 0; heldCnt[i] = 0; rptPhase[i] = 1'b0;
      end
    end else begin
      h2 = h1; h1 = h0; h0 = key_n;
      for (int i = 0; i < NUM_KEYS; i++) begin
        logic sv;
        bit   wasHeld;
        sv = ~h2[i];
        wasHeld = (runLen[i] == 0);
        if (sv != mDown[i]) begin
          runLen[i]++;
          if (runLen[i] == DBC) begin
            mDown[i]  = ~mDown[i];
            runLen[i] = 0;
            if (mDown[i]) begin
              press[i] = 1'b1; heldCnt[i] = 0; rptPhase[i] = 1'b0;
            end else begin
              rel[i] = 1'b1;
            end
          end
        end else begin
`ifdef KEY_REPEAT_EN
          if (mDown[i] && wasHeld) begin
            heldCnt[i]++;
            if (heldCnt[i] == (rptPhase[i] ? RPT_RATE : RPT_DELAY)) begin
              press[i] = 1'b1; heldCnt[i] = 0; rptPhase[i] = 1'b1;
            end
          end
`endif
          runLen[i] = 0;
        end
      end
    end
    if (countEn) modelPressCnt += $countones(press);
    expQ.push_back({mDown, press, rel});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cycleNum++;
      modelStep();
    end
  end

  // Monitor: the DUT presents a result every cycle; compare just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        logic [11:0] e;
        e = expQ.pop_front();
        checkOutput("outputs", {20'h0, key_down, key_press, key_release}, {20'h0, e});
        checkOutput("press_and_release", {28'h0, key_press & key_release}, 32'h0);
        if (countEn) dutPressCnt += $countones(key_press);
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_KEYS-1:0] kn, input int cycles);
    key_n = kn;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'hF, 10);

    // Clean press and release on key 3
    applyStimulus(4'b0111, 20);
    applyStimulus(4'hF, 20);

    // Bounce on key 0, then a hold with short release glitches
    applyStimulus(4'b1110, 3);
    applyStimulus(4'hF, 2);
    applyStimulus(4'b1110, 20);
    applyStimulus(4'hF, 4);
    applyStimulus(4'b1110, 10);
    applyStimulus(4'hF, 20);

    // Simultaneous press of all keys
    applyStimulus(4'b0000, 20);
    applyStimulus(4'hF, 20);

    // Long hold on key 1: press count must match the model
    countEn = 1'b1;
    applyStimulus(4'b1101, 1000);
    countEn = 1'b0;
    checkOutput("long_hold_press_count", 32'(dutPressCnt), 32'(modelPressCnt));
`ifndef KEY_REPEAT_EN
    checkOutput("long_hold_single_press", 32'(dutPressCnt), 32'd1);
`endif
    applyStimulus(4'hF, 20);

    // Reset during qualification, key kept held through reset release
    applyStimulus(4'b0111, 4);
    reset_n = 1'b0;
    applyStimulus(4'b0111, 2);
    reset_n = 1'b1;
    applyStimulus(4'b0111, 20);

    // Reset while key_down is high must clear outputs at once
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_clear", {20'h0, key_down, key_press, key_release}, 32'h0);
    applyStimulus(4'b0111, 2);
    reset_n = 1'b1;
    applyStimulus(4'hF, 20);

    // Random segments mixing glitches and qualified presses
    for (int seg = 0; seg < 350; seg++) begin
      int dur;
      dur = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 15) : $urandom_range(1, 7);
      applyStimulus(4'($urandom), dur);
    end

    applyStimulus(4'hF, 20);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
